// File: rtl/alu_op_issuer_pkg.sv
// Shared definitions for the ALU micro-op issuer: widths, ALU op encodings, instruction layout.
package alu_op_issuer_pkg;

  localparam int unsigned IW         = 9;
  localparam int unsigned RW         = 3;
  localparam int unsigned SHW        = 3;
  localparam int unsigned kOPW       = 3;
  localparam int unsigned kREMW      = SHW + 1;
  localparam int unsigned kSHIFT_MAX = 8;

  localparam logic [kOPW-1:0] kILLEGAL = 3'b111;

  // Single source of ALU operation encodings; matches the instruction opcode field.
  typedef enum logic [kOPW-1:0] {
    ADD = 3'b000,
    LSH = 3'b001,
    BSH = 3'b010,
    XOR = 3'b011,
    AND = 3'b100,
    SUB = 3'b101,
    CLR = 3'b110
  } op_mne;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic [kOPW-1:0] opc;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   rs;
  } inst_t;

  function automatic logic is_shift(input op_mne op);
    return (op == LSH) || (op == BSH);
  endfunction

endpackage

// File: rtl/alu_op_issuer.sv
// Decodes fetched instructions into ALU micro-ops, expanding LSH/BSH by N into N
// single-bit shift micro-ops, with a no-bubble hand-off between instructions.
module alu_op_issuer
  import alu_op_issuer_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic [IW-1:0] inst,
  output logic          uop_valid,
  input  logic          uop_ready,
  output op_mne         uop_op,
  output logic [RW-1:0] uop_rd,
  output logic [RW-1:0] uop_rs,
  output logic          uop_last,
  output logic          illegal,
  output logic          busy
);

  state_e           state_q, state_d;
  logic [kREMW-1:0] rem_q, rem_d;
  logic             uop_valid_q, uop_valid_d;
  op_mne            op_q, op_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic [RW-1:0]    rs_q, rs_d;
  logic             last_q, last_d;
  logic             illegal_q, illegal_d;

  inst_t            inst_w;
  logic [kREMW-1:0] shift_rem;
  logic             xfer;
  logic             accept;

  assign inst_w    = inst;
  // A zero shift-amount field encodes the maximum shift count.
  assign shift_rem = (inst_w.rs == '0) ? kREMW'(kSHIFT_MAX) : kREMW'(inst_w.rs);
  assign xfer      = uop_valid_q && uop_ready;
  assign inst_ready = !Reset && ((state_q == IDLE) || (uop_ready && last_q));
  assign accept    = inst_valid && inst_ready;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    uop_valid_d = uop_valid_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    last_d      = last_q;
    illegal_d   = 1'b0;

    if ((state_q == ISSUE) && xfer) begin
      if (last_q) begin
        state_d     = IDLE;
        uop_valid_d = 1'b0;
        last_d      = 1'b0;
        rem_d       = '0;
      end else begin
        rem_d  = rem_q - kREMW'(1);
        last_d = (rem_d == kREMW'(1));
      end
    end

    // Accept overrides the drain above, giving back-to-back issue after a last uop.
    if (accept) begin
      if (inst_w.opc == kILLEGAL) begin
        illegal_d   = 1'b1;
        state_d     = IDLE;
        uop_valid_d = 1'b0;
        last_d      = 1'b0;
        rem_d       = '0;
      end else begin
        state_d     = ISSUE;
        uop_valid_d = 1'b1;
        op_d        = op_mne'(inst_w.opc);
        rd_d        = inst_w.rd;
        if (is_shift(op_mne'(inst_w.opc))) begin
          rs_d   = inst_w.rd;
          rem_d  = shift_rem;
          last_d = (shift_rem == kREMW'(1));
        end else begin
          rs_d   = inst_w.rs;
          rem_d  = kREMW'(1);
          last_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      uop_valid_q <= 1'b0;
      op_q        <= ADD;
      rd_q        <= '0;
      rs_q        <= '0;
      last_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      uop_valid_q <= uop_valid_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      last_q      <= last_d;
      illegal_q   <= illegal_d;
    end
  end

  assign uop_valid = uop_valid_q;
  assign uop_op    = op_q;
  assign uop_rd    = rd_q;
  assign uop_rs    = rs_q;
  assign uop_last  = last_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q == ISSUE);

  rem_nonzero_in_issue: assert property (@(posedge Clk) disable iff (Reset)
    (state_q == ISSUE) |-> (rem_q != '0));

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboarded bench for alu_op_issuer: expected uops queued on accept, matched against observed transfers.
module tb_alu_op_issuer;
  import alu_op_issuer_pkg::*;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic       last;
  } exp_t;

  logic       Clk        = 1'b0;
  logic       Reset      = 1'b1;
  logic       inst_valid = 1'b0;
  logic [8:0] inst       = '0;
  logic       uop_ready  = 1'b1;
  logic       inst_ready, uop_valid, uop_last, illegal, busy;
  op_mne      uop_op;
  logic [2:0] uop_rd, uop_rs;

  int   tests    = 0;
  int   fails    = 0;
  bit   rand_rdy = 1'b0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t obs_mem [0:1023];
  int   obs_cyc [0:1023];
  int   obs_wr   = 0;
  int   obs_rd   = 0;

  alu_op_issuer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .uop_valid  (uop_valid),
    .uop_ready  (uop_ready),
    .uop_op     (uop_op),
    .uop_rd     (uop_rd),
    .uop_rs     (uop_rs),
    .uop_last   (uop_last),
    .illegal    (illegal),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  // Record every micro-op transfer (sampled mid-cycle, ahead of the transferring edge).
  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (!Reset && uop_valid && uop_ready && obs_wr < 1024) begin
      obs_mem[obs_wr] = {3'(uop_op), uop_rd, uop_rs, uop_last};
      obs_cyc[obs_wr] = cyc;
      obs_wr = obs_wr + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_expected(input logic [8:0] ins);
    logic [2:0] opc, rd, rs;
    int n;
    opc = ins[8:6];
    rd  = ins[5:3];
    rs  = ins[2:0];
    if (opc == 3'b111) return;
    if (opc == 3'b001 || opc == 3'b010) begin
      n = (rs == 3'd0) ? 8 : int'(rs);
      for (int i = 0; i < n; i++) exp_q.push_back({opc, rd, rd, (i == n - 1)});
    end else begin
      exp_q.push_back({opc, rd, rs, 1'b1});
    end
  endtask

  task automatic send(input logic [8:0] ins, output int waited);
    bit acc = 1'b0;
    waited = 0;
    inst = ins;
    inst_valid = 1'b1;
    while (!acc && waited < 100) begin
      @(negedge Clk);
      if (inst_ready) begin
        acc = 1'b1;
        push_expected(ins);
      end else begin
        waited++;
      end
      @(posedge Clk); #1;
      if (rand_rdy) uop_ready = 1'($urandom_range(0, 1));
    end
    inst_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: inst %b not accepted after %0d cycles, required acceptance", ins, waited);
    end
  endtask

  task automatic wait_idle(output bit timed_out);
    int n = 0;
    while (uop_valid && n < 400) begin
      @(posedge Clk); #1;
      if (rand_rdy) uop_ready = 1'($urandom_range(0, 1));
      n++;
    end
    timed_out = uop_valid;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    tests++; if (uop_valid !== 1'b0) begin fails++; $display("FAIL rst_uop_valid: got %b required 0", uop_valid); end
    tests++; if (uop_op !== ADD) begin fails++; $display("FAIL rst_uop_op: got %0d required 0", uop_op); end
    tests++; if (uop_rd !== 3'd0 || uop_rs !== 3'd0) begin fails++; $display("FAIL rst_regs: got rd=%0d rs=%0d required 0 0", uop_rd, uop_rs); end
    tests++; if (uop_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b required 0", uop_last); end
    tests++; if (illegal !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_flags: got illegal=%b busy=%b required 0 0", illegal, busy); end
    tests++; if (inst_ready !== 1'b0) begin fails++; $display("FAIL rst_inst_ready: got %b required 0", inst_ready); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    tests++; if (inst_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b required 1", inst_ready); end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    int w; bit to; exp_t e; int base;
    uop_ready = 1'b1;
    base = obs_wr;
    send(9'b000_001_010, w);
    send(9'b101_011_100, w);
    tests++; if (w != 0) begin fails++; $display("FAIL b2b_no_bubble: SUB waited %0d cycles, required 0", w); end
    @(negedge Clk);
    tests++;
    if (uop_valid !== 1'b1 || uop_op !== SUB || uop_last !== 1'b1) begin
      fails++; $display("FAIL b2b_second: got valid=%b op=%0d last=%b required 1 5 1", uop_valid, uop_op, uop_last);
    end
    @(posedge Clk); #1;
    wait_idle(to);
    tests++;
    if (obs_wr - base != 2 || obs_cyc[base + 1] - obs_cyc[base] != 1) begin
      fails++; $display("FAIL b2b_spacing: got %0d uops, gap %0d cycles, required 2 uops gap 1", obs_wr - base, obs_cyc[base + 1] - obs_cyc[base]);
    end
    tests++; if (to) begin fails++; $display("FAIL b2b_idle: uop_valid still 1, required 0"); end
    while (obs_rd < obs_wr || exp_q.size() != 0) begin
      tests++;
      if (obs_rd >= obs_wr || exp_q.size() == 0) begin
        fails++; $display("FAIL b2b_count: %0d observed unmatched, %0d expected unmatched, required 0 0", obs_wr - obs_rd, exp_q.size());
        obs_rd = obs_wr; exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin fails++; $display("FAIL b2b_uop: got %h required %h", obs_mem[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_lsh();
    int w; bit to; exp_t e;
    uop_ready = 1'b1;
    send(9'b001_101_011, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      tests++;
      if (inst_ready !== (k == 2) || uop_last !== (k == 2) || uop_op !== LSH || busy !== 1'b1) begin
        fails++; $display("FAIL lsh_step%0d: got ready=%b last=%b op=%0d busy=%b required %b %b 1 1", k, inst_ready, uop_last, uop_op, busy, (k == 2), (k == 2));
      end
      @(posedge Clk); #1;
    end
    tests++; if (uop_valid !== 1'b0) begin fails++; $display("FAIL lsh_end: uop_valid got %b required 0", uop_valid); end
    wait_idle(to);
    tests++; if (to) begin fails++; $display("FAIL lsh_idle: uop_valid still 1, required 0"); end
    while (obs_rd < obs_wr || exp_q.size() != 0) begin
      tests++;
      if (obs_rd >= obs_wr || exp_q.size() == 0) begin
        fails++; $display("FAIL lsh_count: %0d observed unmatched, %0d expected unmatched, required 0 0", obs_wr - obs_rd, exp_q.size());
        obs_rd = obs_wr; exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin fails++; $display("FAIL lsh_uop: got %h required %h", obs_mem[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_bsh_max();
    int w; int k = 0; bit to; exp_t e;
    uop_ready = 1'b1;
    send(9'b010_000_000, w);
    while (uop_valid && k < 20) begin
      @(negedge Clk);
      tests++;
      if (dut.rem_q !== 4'(8 - k) || uop_last !== (k == 7)) begin
        fails++; $display("FAIL bsh_rem%0d: got rem=%0d last=%b required %0d %b", k, dut.rem_q, uop_last, 8 - k, (k == 7));
      end
      @(posedge Clk); #1;
      k++;
    end
    tests++; if (k != 8) begin fails++; $display("FAIL bsh_len: got %0d uop cycles required 8", k); end
    wait_idle(to);
    while (obs_rd < obs_wr || exp_q.size() != 0) begin
      tests++;
      if (obs_rd >= obs_wr || exp_q.size() == 0) begin
        fails++; $display("FAIL bsh_count: %0d observed unmatched, %0d expected unmatched, required 0 0", obs_wr - obs_rd, exp_q.size());
        obs_rd = obs_wr; exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin fails++; $display("FAIL bsh_uop: got %h required %h", obs_mem[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_stall();
    int w; int base; bit to; exp_t e;
    uop_ready = 1'b0;
    base = obs_wr;
    send(9'b011_010_110, w);
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      tests++;
      if (uop_valid !== 1'b1 || {3'(uop_op), uop_rd, uop_rs, uop_last} !== 10'b011_010_110_1) begin
        fails++; $display("FAIL stall_hold%0d: got valid=%b uop=%b required 1 0110101101", c, uop_valid, {3'(uop_op), uop_rd, uop_rs, uop_last});
      end
      @(posedge Clk); #1;
    end
    tests++; if (obs_wr != base) begin fails++; $display("FAIL stall_no_xfer: got %0d transfers required 0", obs_wr - base); end
    uop_ready = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    tests++;
    if (uop_valid !== 1'b0 || obs_wr != base + 1) begin
      fails++; $display("FAIL stall_release: got valid=%b transfers=%0d required 0 1", uop_valid, obs_wr - base);
    end
    @(posedge Clk); #1;
    wait_idle(to);
    while (obs_rd < obs_wr || exp_q.size() != 0) begin
      tests++;
      if (obs_rd >= obs_wr || exp_q.size() == 0) begin
        fails++; $display("FAIL stall_count: %0d observed unmatched, %0d expected unmatched, required 0 0", obs_wr - obs_rd, exp_q.size());
        obs_rd = obs_wr; exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin fails++; $display("FAIL stall_uop: got %h required %h", obs_mem[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_illegal();
    int w; bit to; exp_t e;
    uop_ready = 1'b1;
    send(9'b111_000_000, w);
    @(negedge Clk);
    tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_pulse: got %b required 1", illegal); end
    tests++; if (uop_valid !== 1'b0) begin fails++; $display("FAIL ill_no_uop: got %b required 0", uop_valid); end
    tests++; if (inst_ready !== 1'b1) begin fails++; $display("FAIL ill_ready: got %b required 1", inst_ready); end
    @(posedge Clk); #1;
    @(negedge Clk);
    tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_width: got %b required 0", illegal); end
    @(posedge Clk); #1;
    send(9'b000_111_001, w);
    send(9'b111_000_000, w);
    @(negedge Clk);
    tests++;
    if (illegal !== 1'b1 || uop_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL ill_b2b: got illegal=%b valid=%b busy=%b required 1 0 0", illegal, uop_valid, busy);
    end
    @(posedge Clk); #1;
    wait_idle(to);
    while (obs_rd < obs_wr || exp_q.size() != 0) begin
      tests++;
      if (obs_rd >= obs_wr || exp_q.size() == 0) begin
        fails++; $display("FAIL ill_count: %0d observed unmatched, %0d expected unmatched, required 0 0", obs_wr - obs_rd, exp_q.size());
        obs_rd = obs_wr; exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin fails++; $display("FAIL ill_uop: got %h required %h", obs_mem[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_random();
    int w; bit to; exp_t e;
    logic [2:0] opc, rd, rs;
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      opc = 3'($urandom_range(0, 6));
      rd  = 3'($urandom_range(0, 7));
      rs  = 3'($urandom_range(0, 7));
      send({opc, rd, rs}, w);
    end
    wait_idle(to);
    rand_rdy = 1'b0;
    uop_ready = 1'b1;
    tests++; if (to) begin fails++; $display("FAIL rnd_idle: uop_valid still 1, required 0"); end
    while (obs_rd < obs_wr || exp_q.size() != 0) begin
      tests++;
      if (obs_rd >= obs_wr || exp_q.size() == 0) begin
        fails++; $display("FAIL rnd_count: %0d observed unmatched, %0d expected unmatched, required 0 0", obs_wr - obs_rd, exp_q.size());
        obs_rd = obs_wr; exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        if (obs_mem[obs_rd] !== e) begin fails++; $display("FAIL rnd_uop: got %h required %h", obs_mem[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int w; exp_t e;
    uop_ready = 1'b1;
    send(9'b001_110_101, w);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    tests++;
    if (uop_valid !== 1'b0 || uop_last !== 1'b0 || uop_op !== ADD || uop_rd !== 3'd0 || uop_rs !== 3'd0) begin
      fails++; $display("FAIL rmid_uop: got valid=%b last=%b op=%0d rd=%0d rs=%0d required 0 0 0 0 0", uop_valid, uop_last, uop_op, uop_rd, uop_rs);
    end
    tests++;
    if (busy !== 1'b0 || illegal !== 1'b0 || inst_ready !== 1'b0) begin
      fails++; $display("FAIL rmid_flags: got busy=%b illegal=%b ready=%b required 0 0 0", busy, illegal, inst_ready);
    end
    tests++; if (obs_wr - obs_rd != 2) begin fails++; $display("FAIL rmid_xfers: got %0d transfers required 2", obs_wr - obs_rd); end
    while (obs_rd < obs_wr && exp_q.size() != 0) begin
      tests++;
      e = exp_q.pop_front();
      if (obs_mem[obs_rd] !== e) begin fails++; $display("FAIL rmid_uop_match: got %h required %h", obs_mem[obs_rd], e); end
      obs_rd++;
    end
    obs_rd = obs_wr;
    exp_q.delete();
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    tests++;
    if (busy !== 1'b0 || uop_valid !== 1'b0 || inst_ready !== 1'b1 || illegal !== 1'b0) begin
      fails++; $display("FAIL rmid_idle: got busy=%b valid=%b ready=%b illegal=%b required 0 0 1 0", busy, uop_valid, inst_ready, illegal);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lsh();
    test_bsh_max();
    test_stall();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
